// File: rtl/hilo_mul_unit.sv
// HI/LO register stage wrapped around an external combinational unsigned multiplier.
// Signed requests are reduced to magnitudes on entry and the sign is re-applied on writeback.
module hilo_mul_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result;

    // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    assign result = neg_q ? (~mul_p + ONE_P) : mul_p;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    mul_a_d = (op_signed & op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
                    mul_b_d = (op_signed & op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;
                    neg_d   = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Further starts and MT writes are dropped until the product lands.
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = result;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Scoreboard bench for hilo_mul_unit: products are predicted from signed/unsigned arithmetic
// and compared by an independent monitor whenever done pulses.
module tb_hilo_mul_unit;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          op_signed;
    logic [W-1:0]  op_a, op_b;
    logic          mthi, mtlo;
    logic [W-1:0]  wdata;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] scoreboard[$];
    logic [W-1:0]   hiM, loM;

    hilo_mul_unit #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op_signed(op_signed),
        .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    // Stand-in for the external combinational multiplier.
    assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] refProduct(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic logic [W-1:0] refMag(input bit s, input logic [W-1:0] a);
        longint v;
        v = s ? longint'($signed(a)) : longint'(a);
        return W'(v < 0 ? -v : v);
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mtWrite(input bit hiEn, input bit loEn, input logic [W-1:0] d);
        mthi  = hiEn;
        mtlo  = loEn;
        wdata = d;
        if (hiEn) hiM = d;
        if (loEn) loM = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mt_hi", hi, hiM);
        checkOutput("mt_lo", lo, loM);
        checkOutput("mt_busy", busy, 0);
    endtask

    // Entered at a negedge with inputs idle; returns at the negedge of the done cycle.
    task automatic applyStimulus(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit hiEn, input bit loEn, input logic [W-1:0] wd,
                                 input bit intrude);
        logic [2*W-1:0] prod;
        prod      = refProduct(s, a, b);
        start     = 1'b1;
        op_signed = s;
        op_a      = a;
        op_b      = b;
        mthi      = hiEn;
        mtlo      = loEn;
        wdata     = wd;
        if (hiEn) hiM = wd;
        if (loEn) loM = wd;
        scoreboard.push_back(prod);
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        checkOutput("busy_first", busy, 1);
        checkOutput("done_first", done, 0);
        checkOutput("mul_a", mul_a, refMag(s, a));
        checkOutput("mul_b", mul_b, refMag(s, b));
        checkOutput("hi_first", hi, hiM);
        checkOutput("lo_first", lo, loM);
        if (intrude) begin
            start     = 1'b1;
            op_signed = ~s;
            op_a      = ~a;
            op_b      = a ^ b ^ 32'h5A5A_5A5A;
            mthi      = 1'b1;
            mtlo      = 1'b1;
            wdata     = 32'hDEAD_BEEF;
        end
        for (int i = 2; i <= LAT; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            checkOutput("busy_run", busy, 1);
            checkOutput("done_run", done, 0);
            checkOutput("hi_run", hi, hiM);
            checkOutput("lo_run", lo, loM);
        end
        @(negedge clk);
        checkOutput("busy_end", busy, 0);
        checkOutput("done_end", done, 1);
        hiM = prod[2*W-1:W];
        loM = prod[W-1:0];
    endtask

    task automatic resetMidOp(input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op_signed = 1'b0;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_mul_a", mul_a, 0);
        hiM = '0;
        loM = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            checkOutput("post_rst_busy", busy, 0);
            checkOutput("post_rst_hi", hi, 0);
            checkOutput("post_rst_lo", lo, 0);
        end
    endtask

    // Any done pulse without a pending prediction means a spurious or doubled completion.
    always @(negedge clk) begin
        if (resetn && done) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                logic [2*W-1:0] exp;
                exp = scoreboard.pop_front();
                checkOutput("sb_hi", hi, exp[2*W-1:W]);
                checkOutput("sb_lo", lo, exp[W-1:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        wdata     = '0;
        hiM       = '0;
        loM       = '0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_mul_a", mul_a, 0);
        checkOutput("reset_mul_b", mul_b, 0);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
        mtWrite(1'b1, 1'b1, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);
        idle(2);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        resetMidOp(32'h0000_1234, 32'h0000_5678);
        applyStimulus(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, '0, 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0)
                mtWrite(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            applyStimulus(1'($urandom_range(0, 1)), randOperand(), randOperand(),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom,
                          $urandom_range(0, 4) == 0);
        end

        idle(3);
        checkOutput("scoreboard_drained", 64'(scoreboard.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
